// File: rtl/press_arbiter_if.sv
// Event channel between the press arbiter and the downstream lot FSM.
// The arbiter drives valid/id, the consumer answers with ready.
interface press_arbiter_if #(
   parameter int IDW = 2
);
   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic           evt_ready;

   modport master (output evt_valid, output evt_id, input evt_ready);
   modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/press_arbiter.sv
// Turns N button levels into single-press events, arbitrates them round-robin
// and queues them in a small FIFO for the lot FSM.
module press_arbiter #(
   parameter int N     = 4,
   parameter int DEPTH = 4,
   parameter int IDW   = $clog2(N)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N-1:0]               btn,
   press_arbiter_if.master            ev,
   output logic [$clog2(DEPTH):0]     evt_count,
   output logic                       drop,
   input  logic                       clr_drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [N-1:0]   prev_reg, pending_reg, pending_next;
   logic [IDW-1:0] rr_ptr_reg, rr_ptr_next;
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0]  count_reg, count_next;
   logic           drop_reg, drop_next;
   logic           evt_valid_reg, evt_valid_next;
   logic [IDW-1:0] evt_id_reg, evt_id_next;
   logic [IDW-1:0] mem [DEPTH];

   logic [N-1:0]   rise, grant_mask, scan_hit;
   logic [IDW-1:0] scan_idx [N];
   logic           grant_valid, pop, can_accept, merge;
   logic [IDW-1:0] grant_id;

   assign rise       = btn & ~prev_reg;
   assign pop        = evt_valid_reg & ev.evt_ready;
   assign can_accept = (count_reg < CW'(DEPTH)) | pop;

   // Slot gi of the scan looks at button (rr_ptr + gi) mod N.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_scan
         logic [IDW:0] sum;
         assign sum          = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
         assign scan_idx[gi] = (sum >= (IDW+1)'(N)) ? IDW'(sum - (IDW+1)'(N)) : IDW'(sum);
         assign scan_hit[gi] = pending_reg[scan_idx[gi]];
      end
   endgenerate

   always_comb begin
      grant_valid = 1'b0;
      grant_id    = '0;
      if (can_accept) begin
         for (int k = N - 1; k >= 0; k--) begin
            if (scan_hit[k]) begin
               grant_valid = 1'b1;
               grant_id    = scan_idx[k];
            end
         end
      end
   end

   always_comb begin
      grant_mask   = grant_valid ? (N'(1) << grant_id) : '0;
      merge        = |(rise & pending_reg & ~grant_mask);
      pending_next = (pending_reg & ~grant_mask) | rise;
      rr_ptr_next  = rr_ptr_reg;
      if (grant_valid)
         rr_ptr_next = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);
      drop_next    = merge ? 1'b1 : (clr_drop ? 1'b0 : drop_reg);
      count_next   = count_reg + CW'(grant_valid) - CW'(pop);
   end

   // Head register: a push into an (effectively) empty FIFO bypasses the array.
   always_comb begin
      evt_valid_next = evt_valid_reg;
      evt_id_next    = evt_id_reg;
      if (count_next == '0) begin
         evt_valid_next = 1'b0;
         evt_id_next    = '0;
      end else if (count_reg == '0 || (pop && count_reg == CW'(1))) begin
         evt_valid_next = 1'b1;
         evt_id_next    = grant_id;
      end else if (pop) begin
         evt_valid_next = 1'b1;
         evt_id_next    = mem[rd_ptr_reg + AW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (grant_valid)
         mem[wr_ptr_reg] <= grant_id;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_reg      <= '1;
         pending_reg   <= '0;
         rr_ptr_reg    <= '0;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         drop_reg      <= 1'b0;
         evt_valid_reg <= 1'b0;
         evt_id_reg    <= '0;
      end else begin
         prev_reg      <= btn;
         pending_reg   <= pending_next;
         rr_ptr_reg    <= rr_ptr_next;
         count_reg     <= count_next;
         drop_reg      <= drop_next;
         evt_valid_reg <= evt_valid_next;
         evt_id_reg    <= evt_id_next;
         if (grant_valid)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
   end

   assign ev.evt_valid = evt_valid_reg;
   assign ev.evt_id    = evt_id_reg;
   assign evt_count    = count_reg;
   assign drop         = drop_reg;
endmodule

// File: tb/tb_press_arbiter.sv
// Randomised and directed stimulus against a queue-based press model; a
// negedge monitor checks every presented event against the expected queue.
module tb_press_arbiter;
   localparam int N     = 4;
   localparam int DEPTH = 4;
   localparam int IDW   = $clog2(N);
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  btn;
   logic [CW-1:0] evt_count;
   logic          drop;
   logic          clr_drop;

   press_arbiter_if #(.IDW(IDW)) pa_if ();

   press_arbiter #(.N(N), .DEPTH(DEPTH), .IDW(IDW)) dut (
      .clk      (clk),
      .reset    (reset),
      .btn      (btn),
      .ev       (pa_if),
      .evt_count(evt_count),
      .drop     (drop),
      .clr_drop (clr_drop)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: pending presses as a bit set, queued events as a queue.
   logic [N-1:0] m_prev, m_pend;
   int           m_rr;
   int           m_fifo[$];
   bit           m_drop;
   int           exp_q[$];

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = '1;
      m_pend = '0;
      m_rr   = 0;
      m_fifo.delete();
      m_drop = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_edge();
      logic [N-1:0] r;
      bit           p, can, mrg;
      int           g;
      if (!reset) begin
         model_reset();
         return;
      end
      r   = btn & ~m_prev;
      p   = (m_fifo.size() > 0) && pa_if.evt_ready;
      can = (m_fifo.size() < DEPTH) || p;
      g   = -1;
      if (can) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
      end
      mrg = 1'b0;
      for (int i = 0; i < N; i++)
         if (r[i] && m_pend[i] && i != g) mrg = 1'b1;
      if (p) void'(m_fifo.pop_front());
      if (g >= 0) begin
         m_fifo.push_back(g);
         exp_q.push_back(g);
         m_pend[g] = 1'b0;
         m_rr      = (g + 1) % N;
      end
      m_pend = m_pend | r;
      if (mrg) m_drop = 1'b1;
      else if (clr_drop) m_drop = 1'b0;
      m_prev = btn;
   endtask

   // One clock: model follows the edge, then outputs are compared 1ns later.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("evt_count", int'(evt_count), m_fifo.size());
      chk("evt_valid", int'(pa_if.evt_valid), int'(m_fifo.size() > 0));
      chk("drop", int'(drop), int'(m_drop));
   endtask

   task automatic press(input int b);
      btn = N'(1) << b;
      step();
      btn = '0;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   bit done = 1'b0;

   always @(negedge clk) begin
      if (!done && reset) begin
         if (pa_if.evt_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", int'(pa_if.evt_id), -1);
            end else begin
               chk("evt_id", int'(pa_if.evt_id), exp_q[0]);
               if (pa_if.evt_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("evt_id_idle", int'(pa_if.evt_id), 0);
         end
      end
   end

   initial begin
      reset           = 1'b0;
      btn             = 4'b0001;
      pa_if.evt_ready = 1'b1;
      clr_drop        = 1'b0;
      model_reset();
      idle(3);
      reset = 1'b1;
      idle(10);
      btn = '0;
      idle(2);
      // Press btn0 for 6 cycles: event appears two edges after first sample.
      btn = 4'b0001;
      step();
      chk("latency_t0", int'(pa_if.evt_valid), 0);
      step();
      chk("latency_t1", int'(pa_if.evt_valid), 1);
      idle(4);
      btn = '0;
      idle(4);

      // Simultaneous press of 0,1,3; then 2 alone; then 0 and 2 together.
      btn = 4'b1011; step(); btn = '0; idle(6);
      press(2); idle(3);
      btn = 4'b0101; step(); btn = '0; idle(6);

      // Fill FIFO with 0,1,2,3, fifth press stays pending.
      pa_if.evt_ready = 1'b0;
      press(0); press(1); press(2); press(3); press(0);
      idle(2);
      chk("full_count", int'(evt_count), DEPTH);
      pa_if.evt_ready = 1'b1;
      idle(8);

      // Merge a repeated press while full, then clear drop.
      pa_if.evt_ready = 1'b0;
      press(0); press(1); press(2); press(3); press(1); press(1);
      chk("merge_drop", int'(drop), 1);
      pa_if.evt_ready = 1'b1;
      idle(8);
      clr_drop = 1'b1; step(); clr_drop = 1'b0;
      chk("drop_cleared", int'(drop), 0);

      // Reset with three queued events.
      pa_if.evt_ready = 1'b0;
      press(0); press(1); press(2);
      chk("pre_reset_count", int'(evt_count), 3);
      reset = 1'b0;
      #1;
      chk("async_count", int'(evt_count), 0);
      chk("async_valid", int'(pa_if.evt_valid), 0);
      model_reset();
      btn = 4'b0010;
      idle(2);
      reset = 1'b1;
      pa_if.evt_ready = 1'b1;
      idle(4);
      btn = '0;
      idle(2);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         btn             = N'($urandom);
         pa_if.evt_ready = ($urandom_range(0, 3) != 0);
         clr_drop        = ($urandom_range(0, 15) == 0);
         step();
      end
      btn             = '0;
      pa_if.evt_ready = 1'b1;
      clr_drop        = 1'b0;
      idle(12);
      chk("drained", exp_q.size(), 0);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
